// File: rtl/rx_eth_frame_filter_if.sv
// GMII receive pins, filter configuration and parsed-frame outputs of the RX filter.
// The slave modport is the filter, and the master modport is the PHY/config/consumer side.
interface rx_eth_frame_filter_if #(
    parameter int OCT     = 8,
    parameter int NUM_MAC = 4,
    parameter int IDX_W   = 2,
    parameter int LEN_W   = 16
);
    logic                   RX_DV;
    logic [OCT-1:0]         RXD;
    logic                   RX_ER;
    logic [48*NUM_MAC-1:0]  mac_table;
    logic [NUM_MAC-1:0]     mac_valid;
    logic                   bcast_en;
    logic                   promisc;
    logic                   rx_data_v;
    logic [OCT-1:0]         rx_data;
    logic                   frame_done;
    logic                   frame_ok;
    logic [3:0]             frame_status;
    logic [LEN_W-1:0]       frame_len;
    logic [IDX_W-1:0]       match_idx;
    logic [1:0]             match_type;
    logic [47:0]            rx_src_mac;
    logic [15:0]            rx_len_type;
    logic [15:0]            rx_good_cnt;
    logic [15:0]            rx_bad_cnt;

    modport master (
        output RX_DV, RXD, RX_ER, mac_table, mac_valid, bcast_en, promisc,
        input  rx_data_v, rx_data, frame_done, frame_ok, frame_status, frame_len,
               match_idx, match_type, rx_src_mac, rx_len_type, rx_good_cnt, rx_bad_cnt
    );

    modport slave (
        input  RX_DV, RXD, RX_ER, mac_table, mac_valid, bcast_en, promisc,
        output rx_data_v, rx_data, frame_done, frame_ok, frame_status, frame_len,
               match_idx, match_type, rx_src_mac, rx_len_type, rx_good_cnt, rx_bad_cnt
    );
endinterface

// File: rtl/rx_eth_frame_filter.sv
// GMII RX front end: it delineates frames, filters on a DA table, checks CRC, length and RX_ER, and strips the FCS.
// Payload appears 4 byte-times after it is received. There is no backpressure: GMII cannot be stalled.
module rx_eth_frame_filter #(
    parameter int             OCT     = 8,
    parameter int             NUM_MAC = 4,
    parameter int             IDX_W   = 2,
    parameter int             MIN_LEN = 64,
    parameter int             MAX_LEN = 1518,
    parameter int             LEN_W   = 16,
    parameter logic [OCT-1:0] PRE     = 8'b10101010,
    parameter logic [OCT-1:0] SFD     = 8'b10101011
) (
    input  logic                 RX_CLK,
    input  logic                 rst_n,
    rx_eth_frame_filter_if.slave bus
);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [31:0]            crc_q, crc_d;
    logic [47:0]            sh_q, sh_d;
    logic                   rer_q, rer_d;
    logic [3:0][OCT-1:0]    dly_q, dly_d;
    logic [2:0]             dcnt_q, dcnt_d;
    logic                   data_v_q, data_v_d;
    logic [OCT-1:0]         data_q, data_d;
    logic                   done_q, done_d;
    logic                   ok_q, ok_d;
    logic [3:0]             status_q, status_d;
    logic [LEN_W-1:0]       flen_q, flen_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [1:0]             mtype_q, mtype_d;
    logic [47:0]            src_q, src_d;
    logic [15:0]            lt_q, lt_d;
    logic [15:0]            good_q, good_d;
    logic [15:0]            bad_q, bad_d;

    logic                   take;
    logic [47:0]            da;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   fin;
    logic [3:0]             fin_status;
    logic [LEN_W-1:0]       fin_len;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [OCT-1:0] d);
        logic [31:0] r;
        r = c ^ {{(32-OCT){1'b0}}, d};
        for (int b = 0; b < OCT; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign da = {sh_q[47-OCT:0], bus.RXD};

    // Scan from the top down so that the lowest valid matching entry wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_MAC - 1; i >= 0; i--) begin
            if (bus.mac_valid[i] && (bus.mac_table[48*i +: 48] == da)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        crc_d      = crc_q;
        sh_d       = sh_q;
        rer_d      = rer_q;
        dly_d      = dly_q;
        dcnt_d     = dcnt_q;
        data_v_d   = 1'b0;
        data_d     = data_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        status_d   = status_q;
        flen_d     = flen_q;
        idx_d      = idx_q;
        mtype_d    = mtype_q;
        src_d      = src_q;
        lt_d       = lt_q;
        good_d     = good_q;
        bad_d      = bad_q;
        fin        = 1'b0;
        fin_status = '0;
        fin_len    = len_q;

        take = bus.RX_DV && (state_q inside {DST, SRC, TYPE, PAYLOAD});
        if (take) begin
            crc_d = crc_byte(crc_q, bus.RXD);
            len_d = len_q + LEN_W'(1);
            sh_d  = {sh_q[47-OCT:0], bus.RXD};
            if (bus.RX_ER) rer_d = 1'b1;
        end

        case (state_q)
            WAIT_IDLE, DROP: begin
                if (!bus.RX_DV) state_d = IDLE;
            end
            IDLE: begin
                if (bus.RX_DV) state_d = (bus.RXD == PRE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!bus.RX_DV) begin
                    state_d = DROP;
                end else if (bus.RXD == SFD) begin
                    state_d = DST;
                    cnt_d   = '0;
                    len_d   = '0;
                    crc_d   = 32'hFFFFFFFF;
                    rer_d   = 1'b0;
                    dcnt_d  = '0;
                end else if (bus.RXD != PRE) begin
                    state_d = DROP;
                end
            end
            DST: begin
                if (!bus.RX_DV) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd5) begin
                    cnt_d = '0;
                    if (hit) begin
                        state_d = SRC;
                        idx_d   = hit_idx;
                        mtype_d = 2'd0;
                    end else if (bus.bcast_en && (da == 48'hFFFF_FFFF_FFFF)) begin
                        state_d = SRC;
                        idx_d   = '0;
                        mtype_d = 2'd1;
                    end else if (bus.promisc) begin
                        state_d = SRC;
                        idx_d   = '0;
                        mtype_d = 2'd2;
                    end else begin
                        state_d = DROP;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            SRC, TYPE: begin
                if (!bus.RX_DV) begin
                    // Truncated header: report it as a runt once the DA has been accepted.
                    fin        = 1'b1;
                    fin_status = {1'b0, 1'b1, rer_q, crc_q != CRC_RESIDUE};
                    state_d    = IDLE;
                end else if (state_q == SRC && cnt_q == 3'd5) begin
                    src_d   = da;
                    cnt_d   = '0;
                    state_d = TYPE;
                end else if (state_q == TYPE && cnt_q == 3'd1) begin
                    lt_d    = {sh_q[15-OCT:0], bus.RXD};
                    cnt_d   = '0;
                    state_d = PAYLOAD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            PAYLOAD: begin
                if (!bus.RX_DV) begin
                    fin        = 1'b1;
                    fin_status = {1'b0, len_q < LEN_W'(MIN_LEN), rer_q, crc_q != CRC_RESIDUE};
                    state_d    = IDLE;
                end else if (len_q >= LEN_W'(MAX_LEN)) begin
                    fin        = 1'b1;
                    fin_status = 4'b1000;
                    fin_len    = len_d;
                    state_d    = DROP;
                end else begin
                    // The four youngest bytes may be FCS, so a byte leaves only when four more are behind it.
                    if (dcnt_q == 3'd4) begin
                        data_v_d = 1'b1;
                        data_d   = dly_q[3];
                    end
                    dly_d  = {dly_q[2:0], bus.RXD};
                    dcnt_d = (dcnt_q == 3'd4) ? dcnt_q : dcnt_q + 3'd1;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        if (fin) begin
            done_d   = 1'b1;
            status_d = fin_status;
            ok_d     = (fin_status == 4'b0000);
            flen_d   = fin_len;
            dcnt_d   = '0;
            if (fin_status == 4'b0000) begin
                if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
            end else begin
                if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
            end
        end
    end

    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            crc_q    <= '0;
            sh_q     <= '0;
            rer_q    <= 1'b0;
            dly_q    <= '0;
            dcnt_q   <= '0;
            data_v_q <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            status_q <= '0;
            flen_q   <= '0;
            idx_q    <= '0;
            mtype_q  <= '0;
            src_q    <= '0;
            lt_q     <= '0;
            good_q   <= '0;
            bad_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            crc_q    <= crc_d;
            sh_q     <= sh_d;
            rer_q    <= rer_d;
            dly_q    <= dly_d;
            dcnt_q   <= dcnt_d;
            data_v_q <= data_v_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            status_q <= status_d;
            flen_q   <= flen_d;
            idx_q    <= idx_d;
            mtype_q  <= mtype_d;
            src_q    <= src_d;
            lt_q     <= lt_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
        end
    end

    assign bus.rx_data_v    = data_v_q;
    assign bus.rx_data      = data_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_ok     = ok_q;
    assign bus.frame_status = status_q;
    assign bus.frame_len    = flen_q;
    assign bus.match_idx    = idx_q;
    assign bus.match_type   = mtype_q;
    assign bus.rx_src_mac   = src_q;
    assign bus.rx_len_type  = lt_q;
    assign bus.rx_good_cnt  = good_q;
    assign bus.rx_bad_cnt   = bad_q;
endmodule

// File: doc/rx_eth_frame_filter.md
Name: rx_eth_frame_filter

Overview:
Parametrised GMII receive front end that supersedes the single-address Ethernet receiver. It delineates frames and filters on a table of NUM_MAC destination addresses, with broadcast and promiscuous modes. It checks the FCS with CRC-32, length and RX_ER, and forwards the payload with the FCS stripped, followed by a per-frame status pulse. It feeds the IPv4/UDP offload chain and the RX memory writer.

Parameters:
OCT, 8, bits per octet
NUM_MAC, 4, number of destination-address filter entries (1..16)
IDX_W, 2, width of match_idx (>= clog2(NUM_MAC), minimum 1)
MIN_LEN, 64, minimum legal frame length in bytes, DST through FCS
MAX_LEN, 1518, maximum legal frame length in bytes
LEN_W, 16, width of frame_len
PRE, 8'b10101010, preamble byte
SFD, 8'b10101011, start-of-frame delimiter byte

Ports:
RX_CLK  in  1  sole clock
rst_n  in  1  asynchronous, active-low reset
RX_DV  in  1  GMII receive data valid
RXD  in  8  GMII receive data
RX_ER  in  1  GMII receive error
mac_table  in  48*NUM_MAC  entry i occupies bits [48i+47:48i]; first wire byte in bits [47:40]
mac_valid  in  NUM_MAC  per-entry enable
bcast_en  in  1  accept ff:ff:ff:ff:ff:ff
promisc  in  1  accept any destination
rx_data_v  out  1  payload byte strobe
rx_data  out  8  payload byte
frame_done  out  1  one-cycle end-of-frame pulse (accepted frames only)
frame_ok  out  1  valid with frame_done; 1 when frame_status==0
frame_status  out  4  {oversize, runt, rx_er, crc_err}
frame_len  out  LEN_W  byte count, DST through FCS
match_idx  out  IDX_W  matching table entry
match_type  out  2  0 = table, 1 = broadcast, 2 = promiscuous
rx_src_mac  out  48  source MAC of the last accepted frame
rx_len_type  out  16  length/type field of the last accepted frame
rx_good_cnt  out  16  saturating count of good frames
rx_bad_cnt  out  16  saturating count of bad frames

Behaviour:
- Reset: all outputs are 0 and the state is WAIT_IDLE. All outputs are registered.
- States: WAIT_IDLE, IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP.
- WAIT_IDLE / DROP: on RX_DV=0 -> IDLE. This stops a frame already in progress at reset release from being parsed.
- IDLE: RX_DV=1 and RXD==PRE -> PREAMBLE. Any other byte with RX_DV=1 -> DROP.
- PREAMBLE:
  - RXD==PRE: stay.
  - RXD==SFD: go to DST, clear byte counter, CRC register <= 32'hFFFFFFFF.
  - Other byte or RX_DV=0: go to DROP. No status is produced.
- CRC: reflected CRC-32, polynomial 0x04C11DB7, one byte per cycle, applied to every byte from the first DST byte through the last FCS byte.
  - No final XOR is applied.
  - Good FCS means the register equals 32'hDEBB20E3 at end of frame.
- frame_len counts every byte from DST onward.
- DST (6 bytes), shifted in MSB-first. The filter decision is made on the 6th byte:
  - lowest valid matching entry -> match_type 0 (table has priority);
  - else all-ones DA with bcast_en -> match_type 1;
  - else promisc -> match_type 2;
  - else DROP silently (no frame_done, no counter change).
  - match_idx is 0 for types 1 and 2.
- SRC (6 bytes): rx_src_mac is updated on the 6th byte.
- TYPE (2 bytes): rx_len_type is updated on the 2nd byte, then -> PAYLOAD.
- Error flags:
  - RX_ER=1 in any cycle from DST through PAYLOAD with RX_DV=1 sets a sticky rx_er flag.
  - RX_DV=0 in DST, SRC or TYPE ends the frame with runt=1. If the frame was still in DST, no status is produced.
- Payload forwarding:
  - Payload bytes pass through a 4-byte delay line.
  - Payload byte k drives rx_data with rx_data_v=1 on the clock edge following the cycle in which payload byte k+4 is on RXD.
  - The last 4 bytes (the FCS) are never forwarded.
  - Frames with fewer than 4 payload bytes forward nothing.
- End of frame: the first cycle with RX_DV=0 in PAYLOAD triggers the following on that edge:
  - frame_done=1 for one cycle;
  - frame_status, frame_ok and frame_len are registered;
  - crc_err=1 if the CRC register != DEBB20E3;
  - runt=1 if frame_len < MIN_LEN;
  - the delay line is flushed;
  - state -> IDLE.
  - frame_status and frame_len hold until the next frame_done.
- Oversize: when frame_len would exceed MAX_LEN, that byte is not forwarded and frame_done fires immediately with oversize=1 (the other status bits are 0). The state -> DROP.
- Counters: on frame_done, rx_good_cnt increments if frame_ok, else rx_bad_cnt increments. Both saturate at 16'hFFFF.
- mac_table, mac_valid, bcast_en and promisc are sampled only at the DST decision. Changes mid-frame affect only later frames.
- An asynchronous reset mid-frame clears the outputs immediately. No frame_done is emitted for the aborted frame.

Test Plan:
1. mac_valid=4'b0100 with entry 2 = 02:00:00:00:00:02; send 7×PRE + SFD, DA = entry 2, 46-byte payload 0x00..0x2D, correct FCS -> 46 rx_data_v strobes carrying 0x00..0x2D in order; frame_done with frame_ok=1, frame_len=64, match_idx=2, match_type=0; rx_good_cnt=1.
2. Same frame with bit 0 of the last FCS byte flipped -> same 46 strobes; frame_status=4'b0001; rx_bad_cnt=1.
3. DA=02:00:00:00:00:09, promisc=0 -> no rx_data_v, no frame_done, counters unchanged. Repeat with promisc=1 -> accepted with match_type=2.
4. DA all-ones with bcast_en=1 and also entry 0 = all-ones (valid) -> match_type=0, match_idx=0. With entry 0 invalid -> match_type=1.
5. 20-byte frame with good FCS -> frame_status=4'b0100, frame_len=20. 1600-byte frame -> frame_done on the 1519th byte with status=4'b1000, no further strobes, next frame received normally.
6. rst_n pulsed low during payload byte 10 -> all outputs 0 immediately. With RX_DV still high the remaining bytes are ignored; the next frame after RX_DV=0 is received correctly.
